// File: rtl/free_list.sv
// Free physical-register tag FIFO between retirement (enq) and rename (deq).
// Flush restores every non-architectural tag to the free state in one cycle.
module free_list #(
  parameter int P_REG_NUM    = 64,
  parameter int ARCH_REG_NUM = 32,
  localparam int DEPTH       = P_REG_NUM - ARCH_REG_NUM,
  localparam int PD_W        = $clog2(P_REG_NUM),
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [PD_W-1:0]  pd_in,
  input  logic             deq,
  output logic [PD_W-1:0]  pd_out,
  output logic             empty,
  input  logic             flush,
  output logic [IDX_W:0]   count
);

  localparam logic [IDX_W:0] PTR_ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] TAIL_RST = {1'b1, {IDX_W{1'b0}}};

  logic [PD_W-1:0]  mem_q [DEPTH];
  logic [PD_W-1:0]  mem_d [DEPTH];
  logic [IDX_W:0]   head_q;
  logic [IDX_W:0]   head_d;
  logic [IDX_W:0]   tail_q;
  logic [IDX_W:0]   tail_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             deq_ok;
  logic             enq_ok;

  always_comb begin
    head_idx = head_q[IDX_W-1:0];
    tail_idx = tail_q[IDX_W-1:0];
    empty    = (head_q == tail_q);
    full     = (head_idx == tail_idx) &&
               (head_q[IDX_W] != tail_q[IDX_W]);
    deq_ok   = deq & ~empty & ~flush;
    enq_ok   = enq & (~full | deq_ok);
    pd_out   = mem_q[head_idx];
    count    = tail_q - head_q;
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    if (enq_ok) begin
      mem_d[tail_idx] = pd_in;
      tail_d          = tail_q + PTR_ONE;
    end
    // Slots between the new tail and the old head still hold the
    // speculatively allocated tags, so a full list is exactly right.
    if (flush) begin
      head_d = {~tail_d[IDX_W], tail_d[IDX_W-1:0]};
    end else if (deq_ok) begin
      head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PD_W'(ARCH_REG_NUM + i);
      end
      head_q <= '0;
      tail_q <= TAIL_RST;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule
